// File: rtl/chromosome_result_serializer_if.sv
// Byte-stream and done/feedback bundle between the chromosome FSM, the
// result serializer and the UART transmitter.
interface chromosome_result_serializer_if #(
  parameter int NUM_SUMS  = 8,
  parameter int SUM_WIDTH = 32
);
  logic                          iDoneProcessing;
  logic [NUM_SUMS*SUM_WIDTH-1:0] iErrorSums;
  logic                          oDoneProcessingFeedback;
  logic [7:0]                    oTxData;
  logic                          oTxValid;
  logic                          iTxReady;
  logic                          oBusy;
  logic [7:0]                    oFrameCount;

  modport master (
    output iDoneProcessing, iErrorSums, iTxReady,
    input  oDoneProcessingFeedback, oTxData, oTxValid, oBusy, oFrameCount
  );
  modport slave (
    input  iDoneProcessing, iErrorSums, iTxReady,
    output oDoneProcessingFeedback, oTxData, oTxValid, oBusy, oFrameCount
  );
endinterface

// File: rtl/chromosome_result_serializer.sv
// Latches the per-output error sums on done and frames them as a checksummed
// byte stream. RESULT_TOTAL_FITNESS_EN appends a saturated 32-bit total.
module chromosome_result_serializer #(
  parameter int         NUM_SUMS    = 8,
  parameter int         SUM_WIDTH   = 32,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input logic iClock,
  input logic iReset,
  chromosome_result_serializer_if.slave bus
);
  localparam int BPS = SUM_WIDTH / 8;
  localparam int PAY = NUM_SUMS * BPS;
  localparam int PW  = (PAY > 1) ? $clog2(PAY) : 1;
`ifdef RESULT_TOTAL_FITNESS_EN
  localparam int TOT_BYTES = 4;
`else
  localparam int TOT_BYTES = 0;
`endif
  localparam int FRAME_LEN = 2 + PAY + TOT_BYTES + 1;
  localparam int IW        = $clog2(FRAME_LEN);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);
  localparam idx_t PAY_END  = idx_t'(2 + PAY);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] FEEDBACK = 2'd2;

  logic [1:0]                    state_q, state_d;
  idx_t                          idx_q, idx_d;
  logic [7:0]                    csum_q, csum_d;
  logic [7:0]                    tx_data_q, tx_data_d;
  logic                          tx_valid_q, tx_valid_d;
  logic                          fb_q, fb_d;
  logic [7:0]                    fc_q, fc_d;
  logic [NUM_SUMS*SUM_WIDTH-1:0] sums_q, sums_d;

  // Payload viewed as bytes in transmit order (sum-major, MS byte first).
  logic [PAY-1:0][7:0] pay_b;
  for (genvar k = 0; k < NUM_SUMS; k++) begin : g_sum
    for (genvar j = 0; j < BPS; j++) begin : g_byte
      assign pay_b[k*BPS + j] = sums_q[k*SUM_WIDTH + SUM_WIDTH-1-8*j -: 8];
    end
  end

`ifdef RESULT_TOTAL_FITNESS_EN
  localparam int   AW      = SUM_WIDTH + 4;
  localparam idx_t TOT_END = idx_t'(2 + PAY + 4);
  logic [31:0]     total_q, total_d, total_c;
  logic [AW-1:0]   acc;
  logic [3:0][7:0] tot_b;
  logic [1:0]      tidx;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_SUMS; k++)
      acc = acc + AW'(bus.iErrorSums[k*SUM_WIDTH +: SUM_WIDTH]);
    total_c = (AW > 32 && |(acc >> 32)) ? 32'hFFFF_FFFF : 32'(acc);
  end
  assign tot_b = total_q;
`endif

  idx_t       nidx;
  logic [PW-1:0] pidx;
  logic [7:0] nxt_byte;

  // Byte to present after the current one is accepted; the tail is the checksum.
  always_comb begin
    nidx     = idx_q + idx_t'(1);
    pidx     = PW'(nidx - idx_t'(2));
    nxt_byte = csum_q ^ tx_data_q;
`ifdef RESULT_TOTAL_FITNESS_EN
    tidx     = 2'(nidx - PAY_END);
`endif
    if (nidx == idx_t'(1))  nxt_byte = fc_q;
    else if (nidx < PAY_END) nxt_byte = pay_b[pidx];
`ifdef RESULT_TOTAL_FITNESS_EN
    else if (nidx < TOT_END) nxt_byte = tot_b[2'd3 - tidx];
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    fb_d       = fb_q;
    fc_d       = fc_q;
    sums_d     = sums_q;
`ifdef RESULT_TOTAL_FITNESS_EN
    total_d    = total_q;
`endif
    case (state_q)
      IDLE: if (bus.iDoneProcessing) begin
        state_d    = SEND;
        sums_d     = bus.iErrorSums;
`ifdef RESULT_TOTAL_FITNESS_EN
        total_d    = total_c;
`endif
        idx_d      = '0;
        csum_d     = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = HEADER_BYTE;
      end
      SEND: if (tx_valid_q && bus.iTxReady) begin
        csum_d = csum_q ^ tx_data_q;
        if (idx_q == LAST_IDX) begin
          state_d    = FEEDBACK;
          tx_valid_d = 1'b0;
          fc_d       = fc_q + 8'd1;
          fb_d       = 1'b1;
        end else begin
          idx_d     = nidx;
          tx_data_d = nxt_byte;
        end
      end
      FEEDBACK: begin
        // Feedback is held for at least one cycle even if done already dropped.
        fb_d = bus.iDoneProcessing;
        if (!bus.iDoneProcessing) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        fb_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      fb_q       <= 1'b0;
      fc_q       <= '0;
      sums_q     <= '0;
`ifdef RESULT_TOTAL_FITNESS_EN
      total_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      fb_q       <= fb_d;
      fc_q       <= fc_d;
      sums_q     <= sums_d;
`ifdef RESULT_TOTAL_FITNESS_EN
      total_q    <= total_d;
`endif
    end
  end

  assign bus.oTxData                 = tx_data_q;
  assign bus.oTxValid                = tx_valid_q;
  assign bus.oDoneProcessingFeedback = fb_q;
  assign bus.oFrameCount             = fc_q;
  assign bus.oBusy                   = (state_q != IDLE);
endmodule

// File: tb/tb_chromosome_result_serializer.sv
// Randomized bench: frames are compared byte-for-byte against a queue built
// from the framing rules, including stalls, mid-frame reset and counter wrap.
module tb_chromosome_result_serializer;
  localparam int NS = 8;
  localparam int SW = 32;

  logic iClock = 1'b0;
  logic iReset = 1'b1;
  always #5 iClock = ~iClock;

  chromosome_result_serializer_if #(.NUM_SUMS(NS), .SUM_WIDTH(SW)) bus();

  chromosome_result_serializer #(.NUM_SUMS(NS), .SUM_WIDTH(SW), .HEADER_BYTE(8'hA5)) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus   (bus)
  );

  int         n_tot = 0;
  int         n_bad = 0;
  logic [7:0] fc_m  = 8'd0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input logic [NS*SW-1:0] s, input logic [7:0] fc);
    logic [SW-1:0]   w;
    logic [7:0]      x;
    longint unsigned tot;
    tot = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(fc);
    for (int k = 0; k < NS; k++) begin
      w = s[k*SW +: SW];
      tot += longint'(w);
      for (int j = 0; j < SW/8; j++) exp_q.push_back(8'(w >> (SW - 8 - 8*j)));
    end
`ifdef RESULT_TOTAL_FITNESS_EN
    if (tot > 64'hFFFF_FFFF) tot = 64'hFFFF_FFFF;
    for (int j = 0; j < 4; j++) exp_q.push_back(8'(tot >> (24 - 8*j)));
`endif
    x = 8'd0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
  endtask

  // rmode: 0 ready always, 1 toggling, 2 random. *_at fire once that many bytes are accepted.
  task automatic run_frame(input logic [NS*SW-1:0] sums, input int rmode,
                           input int corrupt_at, input int drop_at, input int reset_at);
    int         acc, cyc, len;
    bit         stall, rdy;
    logic [7:0] prev_d;
    acc = 0; cyc = 0; stall = 0; prev_d = 8'd0;
    build_exp(sums, fc_m);
    len = exp_q.size();
    chk("idle_busy", 64'(bus.oBusy), 0);
    bus.iErrorSums      = sums;
    bus.iDoneProcessing = 1'b1;
    bus.iTxReady        = 1'b0;
    @(negedge iClock);
    chk("start_valid", 64'(bus.oTxValid), 1);
    chk("start_busy", 64'(bus.oBusy), 1);
    while (acc < len && cyc < 2000) begin
      if (stall) chk("hold_data", 64'(bus.oTxData), 64'(prev_d));
      if (reset_at == acc) begin
        iReset = 1'b1;
        #1;
        chk("rst_valid", 64'(bus.oTxValid), 0);
        chk("rst_fc", 64'(bus.oFrameCount), 0);
        chk("rst_busy", 64'(bus.oBusy), 0);
        fc_m = 8'd0;
        bus.iDoneProcessing = 1'b0;
        bus.iTxReady        = 1'b0;
        @(negedge iClock);
        iReset = 1'b0;
        return;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (!bus.oTxValid) chk("send_valid", 64'(bus.oTxValid), 1);
      if (bus.oTxValid && rdy) begin
        chk($sformatf("byte%0d", acc), 64'(bus.oTxData), 64'(exp_q[acc]));
        acc++;
        stall = 0;
        if (acc == corrupt_at) bus.iErrorSums = '1;
        if (acc == drop_at) bus.iDoneProcessing = 1'b0;
      end else begin
        stall  = bus.oTxValid;
        prev_d = bus.oTxData;
      end
      bus.iTxReady = rdy;
      @(negedge iClock);
      cyc++;
    end
    bus.iTxReady = 1'b0;
    if (cyc >= 2000) chk("timeout", 1, 0);
    if (rmode == 0) chk("b2b_cycles", 64'(cyc), 64'(len));
    fc_m = fc_m + 8'd1;
    chk("end_valid", 64'(bus.oTxValid), 0);
    chk("fb_rise", 64'(bus.oDoneProcessingFeedback), 1);
    chk("fc_inc", 64'(bus.oFrameCount), 64'(fc_m));
    chk("fb_busy", 64'(bus.oBusy), 1);
    if (bus.iDoneProcessing) begin
      @(negedge iClock);
      chk("fb_hold", 64'(bus.oDoneProcessingFeedback), 1);
      bus.iDoneProcessing = 1'b0;
    end
    @(negedge iClock);
    chk("fb_fall", 64'(bus.oDoneProcessingFeedback), 0);
    chk("idle_after", 64'(bus.oBusy), 0);
  endtask

  function automatic logic [NS*SW-1:0] rand_sums();
    logic [NS*SW-1:0] s;
    for (int k = 0; k < NS; k++) s[k*SW +: SW] = $urandom;
    return s;
  endfunction

  initial begin
    logic [NS*SW-1:0] s;
    bus.iDoneProcessing = 1'b0;
    bus.iErrorSums      = '0;
    bus.iTxReady        = 1'b0;
    repeat (2) @(negedge iClock);
    chk("r_valid", 64'(bus.oTxValid), 0);
    chk("r_data", 64'(bus.oTxData), 0);
    chk("r_fb", 64'(bus.oDoneProcessingFeedback), 0);
    chk("r_busy", 64'(bus.oBusy), 0);
    chk("r_fc", 64'(bus.oFrameCount), 0);
    iReset = 1'b0;
    @(negedge iClock);

    run_frame('0, 0, -1, -1, -1);
    for (int k = 0; k < NS; k++) s[k*SW +: SW] = 32'h0102_0300 + 32'(k);
    run_frame(s, 1, -1, -1, -1);
    run_frame(rand_sums(), 2, 4, -1, -1);
    run_frame(rand_sums(), 2, -1, 20, -1);
    run_frame(rand_sums(), 0, -1, -1, 10);
    run_frame(rand_sums(), 2, -1, -1, -1);

`ifdef RESULT_TOTAL_FITNESS_EN
    for (int k = 0; k < NS; k++) s[k*SW +: SW] = 32'h4000_0000;
    run_frame(s, 0, -1, -1, -1);
`endif

    run_frame(rand_sums(), 0, -1, -1, 3);
    for (int f = 0; f < 256; f++) run_frame(rand_sums(), (f % 3 == 0) ? 2 : 0, -1, 1 + (f % 35), -1);
    chk("fc_wrap", 64'(bus.oFrameCount), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
